switch_debounce: RTL

- Upstream conditioning stage for raw mechanical switch and button inputs, placed ahead of the logic that consumes `sw`.
- Synchronises the asynchronous pin into `clk`, then filters bounce. Stability is timed in sample ticks from the existing clock_enable block.
- Delivers a clean level plus single-cycle rise/fall pulses, so downstream counters and toggles act exactly once per press.

---
 rtl/switch_debounce.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Switch conditioner: synchronises a raw pin, then qualifies level changes over i_en ticks.
// Define DEBOUNCE_TOGGLE_EN to add the press-to-toggle output o_toggle.
module switch_debounce #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_TICKS = 16,
    localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic o_toggle
`endif
);

    typedef enum logic [1:0] {
        StLowStable,
        StLowQual,
        StHighStable,
        StHighQual
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sw_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A revert of s is tested before the terminal tick, so it wins a same-cycle race.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StLowStable;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                StLowStable: begin
                    if (s) begin
                        state_q <= StLowQual;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StLowQual: begin
                    if (!s) begin
                        state_q <= StLowStable;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (i_en) begin
                        if (cnt_q == CntLast) begin
                            state_q <= StHighStable;
                            cnt_q   <= '0;
                            sw_q    <= 1'b1;
                            rise_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StHighStable: begin
                    if (!s) begin
                        state_q <= StHighQual;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StHighQual: begin
                    if (s) begin
                        state_q <= StHighStable;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (i_en) begin
                        if (cnt_q == CntLast) begin
                            state_q <= StLowStable;
                            cnt_q   <= '0;
                            sw_q    <= 1'b0;
                            fall_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StLowStable;
                    cnt_q   <= '0;
                    sw_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sw   = sw_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;
    assign o_busy = busy_q;

`ifdef DEBOUNCE_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else if (rise_q) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign o_toggle = toggle_q;
`endif

endmodule
